parity_frame_rx: RTL

//   Serial receiver and checker for parity-protected frames from the three-bit parity generator path.

---
 rtl/parity_link_pkg.sv | 17 +
 rtl/parity_calc.sv | 12 +
 rtl/parity_frame_rx.sv | 118 +++++++++++
 3 files changed

// File: rtl/parity_link_pkg.sv
// Shared definitions for the parity-protected serial link (transmit and receive ends).
package parity_link_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;

    localparam logic START_BIT  = 1'b1;
    localparam int   DEF_DATA_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_DATA = ST_DATA,
        S_PAR  = ST_PAR
    } link_state_e;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a data word; ODD=0 gives even parity, ODD=1 odd parity.
module parity_calc #(
    parameter int DATA_W = 3,
    parameter int ODD    = 0
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_o
);

    assign parity_o = (^data_i) ^ (ODD != 0);

endmodule

// File: rtl/parity_frame_rx.sv
// Serial receiver for start + DATA_W data bits (LSB first) + parity frames.
// Optional macro PARITY_RX_ERRCNT_EN adds a saturating parity-error counter output err_cnt.
module parity_frame_rx
    import parity_link_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              parity_err,
    output logic              busy
`ifdef PARITY_RX_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              fv_q, fv_d;
    logic              calc;
    logic              par_mismatch;

    parity_calc #(.DATA_W(DATA_W), .ODD(ODD)) u_calc (
        .data_i   (shift_q),
        .parity_o (calc)
    );

    assign par_mismatch = (calc != bit_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            fv_q    <= fv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        perr_d  = perr_q;
        fv_d    = 1'b0;
        if (bit_valid) begin
            case (state_q)
                S_IDLE: begin
                    // Clearing the shift register here keeps old bits out of the next word.
                    if (bit_in == START_BIT) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i)) shift_d[i] = bit_in;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) state_d = S_PAR;
                end
                S_PAR: begin
                    data_d  = shift_q;
                    perr_d  = par_mismatch;
                    fv_d    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign frame_valid = fv_q;
    assign parity_err  = perr_q;
    assign busy        = (state_q == S_DATA) || (state_q == S_PAR);

`ifdef PARITY_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts at the same edge that raises frame_valid, so it lines up with the pulse.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bit_valid && (state_q == S_PAR) && par_mismatch && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
